// File: rtl/kal_tx_pkg.sv
// Shared types and frame constants for the Kalman-output UART transmitter.
// The frame length depends on KAL_TX_CHECKSUM_EN.
package kal_tx_pkg;

    localparam logic [7:0] HDR0_DEF = 8'hAB;
    localparam logic [7:0] HDR1_DEF = 8'hBA;

`ifdef KAL_TX_CHECKSUM_EN
    localparam int FRAME_LEN = 11;
`else
    localparam int FRAME_LEN = 10;
`endif

    localparam int IDX_W = $clog2(FRAME_LEN);
    typedef logic [IDX_W-1:0] idx_t;

    // Loading the next byte is folded into the SEND transition, so only two states are registered
    typedef enum logic {F_IDLE, F_SEND} framer_state_e;

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} ser_state_e;

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte serialiser with baud counter; a byte can be accepted on the last stop-bit
// cycle so consecutive bytes leave the line with no gap.
module uart_tx_byte
    import kal_tx_pkg::*;
#(
    parameter int CLK_DIV = 868
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_valid,
    input  logic [7:0] i_data,
    output logic       o_ready,
    output logic       o_tx,
    output logic       o_done
);

    localparam logic [15:0] BAUD_TOP = 16'(CLK_DIV - 1);

    ser_state_e  state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [2:0]  bit_q, bit_d;
    logic [7:0]  sh_q, sh_d;
    logic        bit_end;

    assign bit_end = (cnt_q == 16'd0);

    always_comb begin
        // NOTE: every comb output gets a default first so no path can infer a latch.
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        sh_d    = sh_q;
        o_tx    = 1'b1;
        o_ready = (state_q == S_IDLE) || ((state_q == S_STOP) && bit_end);
        o_done  = (state_q == S_STOP) && bit_end;

        case (state_q)
            S_IDLE: o_tx = 1'b1;
            S_START: begin
                o_tx = 1'b0;
                if (bit_end) begin
                    state_d = S_DATA;
                    cnt_d   = BAUD_TOP;
                    bit_d   = 3'd0;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            S_DATA: begin
                o_tx = sh_q[0];
                if (bit_end) begin
                    cnt_d = BAUD_TOP;
                    sh_d  = {1'b0, sh_q[7:1]};
                    if (bit_q == 3'd7) state_d = S_STOP;
                    else               bit_d   = bit_q + 3'd1;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            S_STOP: begin
                if (bit_end) state_d = S_IDLE;
                else         cnt_d   = cnt_q - 16'd1;
            end
            default: state_d = S_IDLE;
        endcase

        // Handshake wins over the idle/stop fall-through above
        if (i_valid && o_ready) begin
            state_d = S_START;
            cnt_d   = BAUD_TOP;
            sh_d    = i_data;
        end
    end

    // NOTE: sequential state is updated only with non-blocking assignments.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            sh_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            sh_q    <= sh_d;
        end
    end

endmodule

// File: rtl/kalman_out_uart_tx.sv
// Framer for Kalman x/p snapshots: header, big-endian x and p, optional checksum
// byte when KAL_TX_CHECKSUM_EN is defined.
module kalman_out_uart_tx
    import kal_tx_pkg::*;
#(
    parameter int         CLK_DIV = 868,
    parameter logic [7:0] HDR0    = HDR0_DEF,
    parameter logic [7:0] HDR1    = HDR1_DEF
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_trig,
    input  logic signed [31:0] i_x,
    input  logic signed [31:0] i_p,
    output logic               o_tx,
    output logic               o_busy,
    output logic               o_drop,
    output logic               o_frame_done
);

    framer_state_e      state_q, state_d;
    idx_t               idx_q, idx_d;
    logic signed [31:0] x_q, x_d, p_q, p_d;
    logic               drop_q, drop_d;

    logic ser_valid, ser_ready, ser_done;
    logic busy, last_byte, frame_end, accept, advance;
    idx_t       byte_sel;
    logic [7:0] byte_data;

    always_comb begin
        busy      = (state_q == F_SEND);
        last_byte = (idx_q == idx_t'(FRAME_LEN - 1));
        frame_end = busy && ser_done && last_byte;
        // A trigger on the final stop-bit cycle chains straight into the next frame
        accept    = i_trig && (!busy || frame_end);
        advance   = busy && ser_ready && !last_byte;

        state_d = state_q;
        idx_d   = idx_q;
        x_d     = x_q;
        p_d     = p_q;
        drop_d  = i_trig && busy && !accept;

        if (accept) begin
            state_d = F_SEND;
            idx_d   = '0;
            x_d     = i_x;
            p_d     = i_p;
        end else if (advance) begin
            idx_d = idx_q + idx_t'(1);
        end else if (frame_end) begin
            state_d = F_IDLE;
        end

        ser_valid = accept || (busy && !last_byte);
        byte_sel  = accept ? idx_t'(0) : idx_q + idx_t'(1);
    end

    // Header bytes are constants, so byte 0 can go out on the accepting edge before the snapshot lands
    always_comb begin
        byte_data = 8'h00;
        case (int'(byte_sel))
            0: byte_data = HDR0;
            1: byte_data = HDR1;
            2: byte_data = x_q[31:24];
            3: byte_data = x_q[23:16];
            4: byte_data = x_q[15:8];
            5: byte_data = x_q[7:0];
            6: byte_data = p_q[31:24];
            7: byte_data = p_q[23:16];
            8: byte_data = p_q[15:8];
            9: byte_data = p_q[7:0];
`ifdef KAL_TX_CHECKSUM_EN
            10: byte_data = x_q[31:24] + x_q[23:16] + x_q[15:8] + x_q[7:0]
                          + p_q[31:24] + p_q[23:16] + p_q[15:8] + p_q[7:0];
`endif
            default: byte_data = 8'h00;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q <= F_IDLE;
            idx_q   <= '0;
            x_q     <= '0;
            p_q     <= '0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            x_q     <= x_d;
            p_q     <= p_d;
            drop_q  <= drop_d;
        end
    end

    uart_tx_byte #(.CLK_DIV(CLK_DIV)) u_ser (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_valid (ser_valid),
        .i_data  (byte_data),
        .o_ready (ser_ready),
        .o_tx    (o_tx),
        .o_done  (ser_done)
    );

    assign o_busy       = busy;
    assign o_drop       = drop_q;
    assign o_frame_done = frame_end;

endmodule
